// File: rtl/appro_mul_err_acc.sv
// -----------------------------------------------------------------------------
// appro_mul_err_acc
//
// Error-characterisation stage placed behind an 8x8 unsigned approximate
// multiplier. Every accepted beat carries the operands and the approximate
// product. The exact product is recomputed here, and error statistics are
// accumulated over a window of num_samples beats. The host derives ER, MED
// and WCE from these statistics.
//
// Optional feature macro: ERR_BIAS_EN adds the signed error sum output
// sum_err, which lets the host compute the mean error (bias).
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous, active-high reset
//   start        one-cycle pulse that opens a window (accepted in IDLE/DONE)
//   num_samples  window length, latched when start is accepted
//   in_valid     operand/product beat valid
//   in_ready     stage can accept a beat (depends on state and count only)
//   in_a, in_b   operands
//   in_appr      approximate product of in_a and in_b
//   busy         window in progress (RUN or DRAIN)
//   done         statistics final and stable
//   sample_cnt   beats retired in this window (saturating)
//   err_cnt      beats with a nonzero error (saturating)
//   sum_ed       sum of |appr - exact| (saturating)
//   max_ed       largest |appr - exact| seen
//   sum_err      signed sum of (appr - exact), saturating (ERR_BIAS_EN only)
//
// state | meaning
// IDLE  | no window yet, input closed
// RUN   | accepting beats until N have been accepted
// DRAIN | input closed, waiting for the pipeline to retire the last beats
// DONE  | statistics final; start opens a new window
// -----------------------------------------------------------------------------
module appro_mul_err_acc #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 32,
    parameter int ACC_W = 48
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CNT_W-1:0]       num_samples,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    input  logic [2*WIDTH-1:0]     in_appr,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       sample_cnt,
    output logic [CNT_W-1:0]       err_cnt,
    output logic [ACC_W-1:0]       sum_ed,
    output logic [2*WIDTH-1:0]     max_ed
`ifdef ERR_BIAS_EN
    ,
    output logic signed [ACC_W-1:0] sum_err
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]   n_reg;
    logic [CNT_W-1:0]   acc_cnt;
    logic               accept;
    logic               last_accept;
    logic               clr_stats;
    logic               ld_n;

    // S1 registers
    logic               v1;
    logic [WIDTH-1:0]   a1, b1;
    logic [2*WIDTH-1:0] appr1;
    logic [2*WIDTH-1:0] exact1;
    logic [2*WIDTH:0]   diff1;
    logic [2*WIDTH-1:0] ed1;

    // S2 registers
    logic               v2;
    logic [2*WIDTH-1:0] ed2;
    logic               neq2;

    logic [ACC_W:0]     sum_ed_ext;

    assign in_ready    = (state == ST_RUN) && (acc_cnt < n_reg);
    assign accept      = in_valid && in_ready;
    // n_reg is never zero in RUN, so n_reg - 1 does not underflow there
    assign last_accept = (acc_cnt == n_reg - CNT_W'(1));
    assign busy        = (state == ST_RUN) || (state == ST_DRAIN);
    assign done        = (state == ST_DONE);

    // Full-width product; the zero-extension keeps the multiply at 2*WIDTH bits
    assign exact1 = {{WIDTH{1'b0}}, a1} * {{WIDTH{1'b0}}, b1};
    // One extra bit so the sign of appr - exact is available for |.| and bias
    assign diff1  = {1'b0, appr1} - {1'b0, exact1};
    assign ed1    = diff1[2*WIDTH] ? (exact1 - appr1) : (appr1 - exact1);

    assign sum_ed_ext = {1'b0, sum_ed} + {{(ACC_W+1-2*WIDTH){1'b0}}, ed2};

`ifdef ERR_BIAS_EN
    logic [2*WIDTH:0]   diff2;
    logic [ACC_W:0]     sum_err_ext;
    assign sum_err_ext = {sum_err[ACC_W-1], sum_err}
                       + {{(ACC_W-2*WIDTH){diff2[2*WIDTH]}}, diff2};
`endif

    always_comb begin
        state_nxt = state;
        clr_stats = 1'b0;
        ld_n      = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    clr_stats = 1'b1;
                    ld_n      = 1'b1;
                    state_nxt = (num_samples != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (accept && last_accept) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                // An empty S2 means the S3 update of the last beat has landed
                if (!v1 && !v2) state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            n_reg      <= '0;
            acc_cnt    <= '0;
            v1         <= 1'b0;
            a1         <= '0;
            b1         <= '0;
            appr1      <= '0;
            v2         <= 1'b0;
            ed2        <= '0;
            neq2       <= 1'b0;
            sample_cnt <= '0;
            err_cnt    <= '0;
            sum_ed     <= '0;
            max_ed     <= '0;
`ifdef ERR_BIAS_EN
            diff2      <= '0;
            sum_err    <= '0;
`endif
        end else begin
            state <= state_nxt;

            if (ld_n) begin
                n_reg   <= num_samples;
                acc_cnt <= '0;
            end else if (accept) begin
                acc_cnt <= acc_cnt + CNT_W'(1);
            end

            v1 <= accept;
            if (accept) begin
                a1    <= in_a;
                b1    <= in_b;
                appr1 <= in_appr;
            end

            v2 <= v1;
            if (v1) begin
                ed2  <= ed1;
                neq2 <= (ed1 != '0);
`ifdef ERR_BIAS_EN
                diff2 <= diff1;
`endif
            end

            if (clr_stats) begin
                sample_cnt <= '0;
                err_cnt    <= '0;
                sum_ed     <= '0;
                max_ed     <= '0;
`ifdef ERR_BIAS_EN
                sum_err    <= '0;
`endif
            end else if (v2) begin
                if (sample_cnt != '1) sample_cnt <= sample_cnt + CNT_W'(1);
                if (neq2 && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
                sum_ed <= sum_ed_ext[ACC_W] ? '1 : sum_ed_ext[ACC_W-1:0];
                if (ed2 > max_ed) max_ed <= ed2;
`ifdef ERR_BIAS_EN
                // Sign of the wide sum differs from the narrow one only on overflow
                if (sum_err_ext[ACC_W] != sum_err_ext[ACC_W-1])
                    sum_err <= sum_err_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                                  : {1'b0, {(ACC_W-1){1'b1}}};
                else
                    sum_err <= sum_err_ext[ACC_W-1:0];
`endif
            end
        end
    end

endmodule

// File: tb/tb_appro_mul_err_acc.sv
module tb_appro_mul_err_acc;
    localparam int W  = 8;
    localparam int CW = 32;
    localparam int AW = 48;

    logic            clk = 1'b0;
    logic            rst, start, in_valid;
    logic [CW-1:0]   num_samples;
    logic [W-1:0]    in_a, in_b;
    logic [2*W-1:0]  in_appr;
    logic            in_ready, busy, done;
    logic [CW-1:0]   sample_cnt, err_cnt;
    logic [AW-1:0]   sum_ed;
    logic [2*W-1:0]  max_ed;
`ifdef ERR_BIAS_EN
    logic signed [AW-1:0] sum_err;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;

    appro_mul_err_acc #(.WIDTH(W), .CNT_W(CW), .ACC_W(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_samples (num_samples),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_appr     (in_appr),
        .busy        (busy),
        .done        (done),
        .sample_cnt  (sample_cnt),
        .err_cnt     (err_cnt),
        .sum_ed      (sum_ed),
        .max_ed      (max_ed)
`ifdef ERR_BIAS_EN
        ,
        .sum_err     (sum_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_s(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat for exactly one edge; in_ready must already be high
    task automatic beat(input int a, input int b, input int p);
        in_a     = W'(a);
        in_b     = W'(b);
        in_appr  = (2*W)'(p);
        in_valid = 1'b1;
        chk("ready_for_beat", in_ready, 1);
        tick();
    endtask

    task automatic start_win(input int n);
        num_samples = CW'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int c);
        c = 0;
        while (!done && c < 20) begin
            tick();
            c++;
        end
        chk("done_reached", done, 1);
    endtask

    task automatic chk_stats(input string tag, input int s, input int e, input int sum, input int mx);
        chk({tag, "_sample_cnt"}, sample_cnt, s);
        chk({tag, "_err_cnt"},    err_cnt,    e);
        chk({tag, "_sum_ed"},     sum_ed,     sum);
        chk({tag, "_max_ed"},     max_ed,     mx);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; num_samples = '0;
        in_a = '0; in_b = '0; in_appr = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk_stats("rst", 0, 0, 0, 0);

        // Window of 3, back-to-back beats: only 10*10 -> 96 is wrong (ed 4)
        start_win(3);
        chk("t1_busy", busy, 1);
        beat(3, 5, 15);
        beat(10, 10, 96);
        beat(255, 255, 65025);
        in_valid = 1'b0;
        chk("t1_ready_drop", in_ready, 0);
        chk("t1_busy_drain", busy, 1);
        wait_done(cyc);
        chk_stats("t1", 3, 1, 4, 4);

        // Window of 4 with gaps: 7*9=63 vs 60 (ed 3), 2*2=4 vs 8 (ed 4)
        start_win(4);
        beat(7, 9, 60);   in_valid = 1'b0; tick();
        beat(0, 0, 0);    in_valid = 1'b0; tick();
        beat(2, 2, 8);    in_valid = 1'b0; tick();
        beat(200, 3, 600);
        in_valid = 1'b0;
        wait_done(cyc);
        chk("t2_done_latency", cyc, 3);
        chk_stats("t2", 4, 2, 7, 4);

        // Zero-length window from IDLE; offered beats must not be taken
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t3_idle_done", done, 0);
        in_a = 8'd1; in_b = 8'd1; in_appr = 16'd5; in_valid = 1'b1;
        start_win(0);
        chk("t3_done_next", done, 1);
        chk("t3_busy", busy, 0);
        chk("t3_ready", in_ready, 0);
        tick(); tick(); tick();
        in_valid = 1'b0;
        chk_stats("t3", 0, 0, 0, 0);

        // Two beats of |err|=1, then restart from DONE with a one-beat window
        start_win(2);
        beat(2, 3, 7);
        beat(4, 4, 15);
        in_valid = 1'b0;
        wait_done(cyc);
        chk_stats("t4a", 2, 2, 2, 1);
        start_win(1);
        chk("t4_cleared_sample", sample_cnt, 0);
        chk("t4_cleared_sum", sum_ed, 0);
        chk("t4_busy", busy, 1);
        beat(1, 1, 0);
        in_valid = 1'b0;
        wait_done(cyc);
        chk_stats("t4b", 1, 1, 1, 1);

        // Reset with two beats still in the pipeline
        start_win(5);
        beat(2, 2, 7);
        beat(3, 3, 4);
        in_valid = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_ready", in_ready, 0);
        tick(); tick(); tick(); tick();
        chk_stats("t5_flush", 0, 0, 0, 0);

        // Errors of +3 and -5
        start_win(2);
        beat(2, 2, 7);
        beat(3, 3, 4);
        in_valid = 1'b0;
        wait_done(cyc);
        chk_stats("t6", 2, 2, 8, 5);
`ifdef ERR_BIAS_EN
        chk_s("t6_sum_err", longint'(sum_err), -2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
